// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: scans W-bit chunks MSB-first and stops at the
// first differing chunk, reporting e/g/l and the highest differing bit index.
module seq_mag_comp #(
    parameter int N = 8,
    parameter int W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [N-1:0]         a,
    input  logic [N-1:0]         b,
    output logic                 busy,
    output logic                 done,
    output logic                 e,
    output logic                 g,
    output logic                 l,
    output logic [$clog2(N)-1:0] msb_diff
);
    localparam int NCH  = N / W;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MSBW = $clog2(N);

    generate
        if (N < 2 || W < 1 || W > N || (N % W) != 0) begin : g_param_err
            $error("seq_mag_comp: need N >= 2, 1 <= W <= N and N a multiple of W");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state, w_state_n;
    logic [N-1:0]    r_a, r_b;
    logic [IDXW-1:0] r_idx;
    logic            r_e, r_g, r_l;
    logic [MSBW-1:0] r_msb;

    logic [N-1:0]    w_flip;
    logic [W-1:0]    w_ca, w_cb;
    logic [MSBW-1:0] w_pos;
    logic            w_diff, w_last;

    // Offset-binary: flipping the sign bit of both operands makes an unsigned
    // scan produce the two's-complement order; bit positions are unchanged.
    assign w_flip = {signed_mode, {(N-1){1'b0}}};

    always_comb begin
        w_ca  = '0;
        w_cb  = '0;
        w_pos = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_ca = r_a[i*W +: W];
                w_cb = r_b[i*W +: W];
                for (int j = 0; j < W; j++) begin
                    if (r_a[i*W+j] != r_b[i*W+j]) w_pos = MSBW'(i*W + j);
                end
            end
        end
    end

    assign w_diff = (w_ca != w_cb);
    assign w_last = (r_idx == '0);

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_n = S_RUN;
            S_RUN:   if (w_diff || w_last) w_state_n = S_DONE;
            S_DONE:  w_state_n = S_IDLE;
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            r_e   <= 1'b0;
            r_g   <= 1'b0;
            r_l   <= 1'b0;
            r_msb <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= a ^ w_flip;
                        r_b   <= b ^ w_flip;
                        r_idx <= IDXW'(NCH - 1);
                        r_e   <= 1'b0;
                        r_g   <= 1'b0;
                        r_l   <= 1'b0;
                        r_msb <= '0;
                    end
                end
                S_RUN: begin
                    if (w_diff) begin
                        r_g   <= (w_ca > w_cb);
                        r_l   <= (w_ca < w_cb);
                        r_msb <= w_pos;
                    end else if (w_last) begin
                        r_e   <= 1'b1;
                        r_msb <= '0;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = (r_state == S_DONE);
    assign e        = r_e;
    assign g        = r_g;
    assign l        = r_l;
    assign msb_diff = r_msb;
endmodule

// File: tb/tb_seq_mag_comp.sv
// Scoreboard bench for seq_mag_comp: three instances (W = 2, 8, 1) with N = 8,
// expected results and done timing come from an arithmetic reference model.
module tb_seq_mag_comp;
    typedef struct {
        logic       e, g, l;
        logic [2:0] msb;
        int         done_edge;
        int         free_edge;
    } exp_t;

    logic       clk, rst;
    logic       start [3];
    logic       sm    [3];
    logic [7:0] a     [3];
    logic [7:0] b     [3];
    logic [2:0] busy, done, e, g, l;
    logic [2:0] mdiff [3];

    int   total = 0, bad = 0;
    int   edge_no = 0;
    int   free_e [3];
    exp_t last   [3];
    exp_t q      [3][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gk = 0; gk < 3; gk++) begin : g_dut
        seq_mag_comp #(.N(8), .W(gk == 0 ? 2 : (gk == 1 ? 8 : 1))) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start[gk]),
            .signed_mode(sm[gk]),
            .a          (a[gk]),
            .b          (b[gk]),
            .busy       (busy[gk]),
            .done       (done[gk]),
            .e          (e[gk]),
            .g          (g[gk]),
            .l          (l[gk]),
            .msb_diff   (mdiff[gk])
        );
    end

    function automatic int wof(int k);
        return (k == 0) ? 2 : ((k == 1) ? 8 : 1);
    endfunction

    // Reference: compare as integers, find the top differing bit, and derive
    // latency from how many whole W-bit chunks lie above that bit.
    function automatic exp_t ref_cmp(input logic [7:0] ra, input logic [7:0] rb,
                                     input logic rsm, input int w, input int c0);
        exp_t r;
        int av, bv, msb, k;
        av = rsm ? int'($signed(ra)) : int'(ra);
        bv = rsm ? int'($signed(rb)) : int'(rb);
        r.e = (av == bv);
        r.g = (av > bv);
        r.l = (av < bv);
        msb = 0;
        for (int i = 0; i < 8; i++) if (ra[i] != rb[i]) msb = i;
        r.msb = 3'(msb);
        k = r.e ? (8 / w - 1) : ((7 - msb) / w);
        r.done_edge = c0 + k + 1;
        r.free_edge = c0 + k + 3;
        return r;
    endfunction

    task automatic chk(input string nm, input int k, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s dut%0d edge=%0d got=%0d expected=%0d", nm, k, edge_no, got, expv);
        end
    endtask

    // Model: decides acceptance at each rising edge from its own notion of when
    // each instance is free again.
    initial begin
        exp_t x;
        for (int k = 0; k < 3; k++) begin
            free_e[k] = 0;
            last[k]   = '{1'b0, 1'b0, 1'b0, 3'd0, 0, 0};
        end
        forever begin
            @(posedge clk);
            edge_no++;
            for (int k = 0; k < 3; k++) begin
                if (rst) begin
                    q[k].delete();
                    last[k]   = '{1'b0, 1'b0, 1'b0, 3'd0, 0, 0};
                    free_e[k] = edge_no + 1;
                end else if (start[k] && edge_no >= free_e[k]) begin
                    x = ref_cmp(a[k], b[k], sm[k], wof(k), edge_no);
                    q[k].push_back(x);
                    free_e[k] = x.free_edge;
                end
            end
        end
    end

    // Monitor
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 3; m++) begin
                chk("busy", m, int'(busy[m]), int'(q[m].size() != 0));
                if (done[m]) begin
                    if (q[m].size() == 0) begin
                        chk("spurious_done", m, int'(done[m]), 0);
                    end else begin
                        x = q[m].pop_front();
                        chk("done_edge", m, edge_no, x.done_edge);
                        chk("e", m, int'(e[m]), int'(x.e));
                        chk("g", m, int'(g[m]), int'(x.g));
                        chk("l", m, int'(l[m]), int'(x.l));
                        chk("msb_diff", m, int'(mdiff[m]), int'(x.msb));
                        last[m] = x;
                    end
                end else if (q[m].size() != 0 && q[m][0].done_edge <= edge_no) begin
                    chk("done_missing", m, int'(done[m]), 1);
                    x = q[m].pop_front();
                end else if (q[m].size() != 0) begin
                    chk("egl_run", m, int'({e[m], g[m], l[m]}), 0);
                    chk("msb_run", m, int'(mdiff[m]), 0);
                end else begin
                    chk("egl_hold", m, int'({e[m], g[m], l[m]}),
                        int'({last[m].e, last[m].g, last[m].l}));
                    chk("msb_hold", m, int'(mdiff[m]), int'(last[m].msb));
                end
            end
        end
    end

    task automatic issue(input int k, input logic [7:0] va, input logic [7:0] vb, input logic vsm);
        @(negedge clk);
        a[k] = va; b[k] = vb; sm[k] = vsm; start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0; a[k] = 8'($urandom); b[k] = 8'($urandom); sm[k] = 1'($urandom);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0; sm[k] = 1'b0; a[k] = 8'h00; b[k] = 8'h00;
        end
        wait_n(3);
        rst = 1'b0;
        wait_n(2);

        issue(0, 8'hA5, 8'h5A, 1'b0); wait_n(8);
        issue(0, 8'h3C, 8'h3C, 1'b0); wait_n(8);
        issue(0, 8'h12, 8'h13, 1'b0); wait_n(8);
        issue(0, 8'h12, 8'h32, 1'b0); wait_n(8);
        issue(0, 8'h80, 8'h01, 1'b1); wait_n(8);
        issue(0, 8'h80, 8'h01, 1'b0); wait_n(8);
        issue(0, 8'hFF, 8'hFE, 1'b1); wait_n(8);

        // Abort in the second RUN cycle
        @(negedge clk);
        a[0] = 8'h00; b[0] = 8'h00; sm[0] = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_n(8);
        issue(0, 8'h01, 8'h00, 1'b0); wait_n(8);

        // start held high with operands changing every cycle
        @(negedge clk);
        start[0] = 1'b1;
        repeat (24) begin
            @(negedge clk);
            a[0] = 8'($urandom); b[0] = 8'($urandom); sm[0] = 1'($urandom);
        end
        start[0] = 1'b0;
        wait_n(8);

        issue(1, 8'hA5, 8'h5A, 1'b0); wait_n(4);
        issue(2, 8'hA5, 8'h5A, 1'b0); wait_n(6);
        issue(2, 8'h01, 8'h00, 1'b0); wait_n(14);

        repeat (3000) begin
            @(negedge clk);
            rst = ($urandom_range(0, 249) == 0);
            for (int k = 0; k < 3; k++) begin
                start[k] = ($urandom_range(0, 3) == 0);
                sm[k]    = 1'($urandom);
                a[k]     = 8'($urandom);
                case ($urandom_range(0, 3))
                    0:       b[k] = a[k];
                    1:       b[k] = a[k] ^ (8'd1 << $urandom_range(0, 7));
                    default: b[k] = 8'($urandom);
                endcase
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        wait_n(20);

        for (int k = 0; k < 3; k++) chk("pending_at_end", k, q[k].size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
